cyp_fifo_arbiter: RTL and testbench

CYP_FIFO_ARBITER -- requirements
Module: cyp_fifo_arbiter

---
 rtl/cyp_pkg.sv | 21 ++
 rtl/cyp_fifo_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cyp_fifo_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cyp_pkg.sv
// Shared constants for the FX2 slave-FIFO arbiter: state codes, endpoint
// codes and default burst / packet-end timing.
package cyp_pkg;

  localparam int unsigned ST_W   = 3;
  localparam int unsigned BCNT_W = 9;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ADDR  = 3'd1;
  localparam logic [2:0] ST_RD_BURST = 3'd2;
  localparam logic [2:0] ST_WR_ADDR  = 3'd3;
  localparam logic [2:0] ST_WR_BURST = 3'd4;
  localparam logic [2:0] ST_TURN     = 3'd5;

  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP6 = 2'b10;

  localparam int unsigned MAX_BURST_DEF = 256;
  localparam int unsigned PKTEND_TO_DEF = 64;

endpackage

// File: rtl/cyp_fifo_arbiter.sv
// FX2 slave-FIFO arbiter: round-robin between EP2 OUT reads (into the
// receive FIFO) and EP6 IN writes (from the transmit FIFO), with bounded
// bursts and a turnaround cycle between them.
// Optional feature: define CYP_PKTEND_EN to commit short IN packets with a
// usb_pktend pulse after PKTEND_TO idle cycles.
module cyp_fifo_arbiter
  import cyp_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned PKTEND_TO = PKTEND_TO_DEF
) (
  input  logic        cyp_clk,
  input  logic        rst_n,
  input  logic        usb_flaga,
  input  logic        usb_flagc,
  input  logic [15:0] usb_fd_i,
  input  logic        rx_full,
  input  logic        tx_empty,
  input  logic [15:0] tx_rdata,
  output logic [1:0]  usb_fifoaddr,
  output logic        usb_slcs,
  output logic        usb_sloe,
  output logic        usb_slrd,
  output logic        usb_slwr,
  output logic        usb_pktend,
  output logic [15:0] usb_fd_o,
  output logic        usb_fd_oe,
  output logic        rx_wen,
  output logic [15:0] rx_wdata,
  output logic        tx_ren
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [BCNT_W:0]   bcnt_inc;
  logic              rd_pri_q, rd_pri_d;
  logic [1:0]        fifoaddr_q, fifoaddr_d;
  logic              rd_req, wr_req;
  logic              pktend_fire;

  assign rd_req   = usb_flaga & ~rx_full;
  assign wr_req   = usb_flagc & ~tx_empty;
  assign usb_slcs = 1'b0;

`ifdef CYP_PKTEND_EN
  localparam int unsigned IDLE_W = $clog2(PKTEND_TO + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [BCNT_W-1:0] wtot_q, wtot_d;

  // Short-packet commit fires once the idle timeout is reached with words pending
  assign pktend_fire = (state_q == ST_IDLE) && (wtot_q != '0) &&
                       (idle_q == IDLE_W'(PKTEND_TO)) && tx_empty;

  // Idle timer and words-since-commit (wraps at 512: a full packet commits itself)
  always_comb begin
    idle_d = idle_q;
    wtot_d = wtot_q;
    if (pktend_fire) begin
      idle_d = '0;
      wtot_d = '0;
    end else begin
      if (state_q != ST_IDLE) begin
        idle_d = '0;
      end else if ((wtot_q != '0) && (idle_q != IDLE_W'(PKTEND_TO))) begin
        idle_d = idle_q + IDLE_W'(1);
      end
      if ((state_q == ST_WR_BURST) && wr_req) begin
        wtot_d = wtot_q + BCNT_W'(1);
      end
    end
  end

  // Packet-end bookkeeping registers
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      wtot_q <= '0;
    end else begin
      idle_q <= idle_d;
      wtot_q <= wtot_d;
    end
  end

  assign usb_pktend = ~pktend_fire;
`else
  assign pktend_fire = 1'b0;
  assign usb_pktend  = 1'b1;
`endif

  // State, burst count, round-robin pointer and endpoint select
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= '0;
      rd_pri_q   <= 1'b1;
      fifoaddr_q <= EP2;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      rd_pri_q   <= rd_pri_d;
      fifoaddr_q <= fifoaddr_d;
    end
  end

  // Next-state logic and strobes decoded from registered state plus live flags
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    rd_pri_d     = rd_pri_q;
    fifoaddr_d   = fifoaddr_q;
    bcnt_inc     = {1'b0, bcnt_q} + (BCNT_W+1)'(1);
    usb_sloe     = 1'b1;
    usb_slrd     = 1'b1;
    usb_slwr     = 1'b1;
    usb_fd_oe    = 1'b0;
    rx_wen       = 1'b0;
    tx_ren       = 1'b0;
    usb_fd_o     = tx_rdata;
    rx_wdata     = usb_fd_i;
    usb_fifoaddr = pktend_fire ? EP6 : fifoaddr_q;

    case (state_q)
      ST_IDLE: begin
        // a commit cycle owns the bus; arbitration resumes next cycle
        if (!pktend_fire) begin
          if (rd_req && (!wr_req || rd_pri_q)) begin
            state_d    = ST_RD_ADDR;
            fifoaddr_d = EP2;
            rd_pri_d   = 1'b0;
          end else if (wr_req) begin
            state_d    = ST_WR_ADDR;
            fifoaddr_d = EP6;
            rd_pri_d   = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        bcnt_d  = '0;
        state_d = ST_RD_BURST;
      end
      ST_RD_BURST: begin
        usb_sloe = 1'b0;
        if (rd_req) begin
          usb_slrd = 1'b0;
          rx_wen   = 1'b1;
          bcnt_d   = bcnt_inc[BCNT_W-1:0];
          if (bcnt_inc == (BCNT_W+1)'(MAX_BURST)) begin
            state_d = ST_TURN;
          end
        end else begin
          state_d = ST_TURN;
        end
      end
      ST_WR_ADDR: begin
        bcnt_d  = '0;
        state_d = ST_WR_BURST;
      end
      ST_WR_BURST: begin
        usb_fd_oe = 1'b1;
        if (wr_req) begin
          usb_slwr = 1'b0;
          tx_ren   = 1'b1;
          bcnt_d   = bcnt_inc[BCNT_W-1:0];
          if (bcnt_inc == (BCNT_W+1)'(MAX_BURST)) begin
            state_d = ST_TURN;
          end
        end else begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cyp_fifo_arbiter.sv
// Bench for cyp_fifo_arbiter: a phase-level model checked every cycle plus
// hand-computed expectations for the key scenarios.
module tb_cyp_fifo_arbiter;

  localparam int MAXB = 256;
  localparam int TO   = 64;

  logic        cyp_clk = 1'b0;
  logic        rst_n;
  logic        usb_flaga, usb_flagc, rx_full, tx_empty;
  logic [15:0] usb_fd_i, tx_rdata;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend;
  logic [15:0] usb_fd_o, rx_wdata;
  logic        usb_fd_oe, rx_wen, tx_ren;

  cyp_fifo_arbiter dut (
    .cyp_clk(cyp_clk), .rst_n(rst_n),
    .usb_flaga(usb_flaga), .usb_flagc(usb_flagc), .usb_fd_i(usb_fd_i),
    .rx_full(rx_full), .tx_empty(tx_empty), .tx_rdata(tx_rdata),
    .usb_fifoaddr(usb_fifoaddr), .usb_slcs(usb_slcs), .usb_sloe(usb_sloe),
    .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_pktend(usb_pktend),
    .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe),
    .rx_wen(rx_wen), .rx_wdata(rx_wdata), .tx_ren(tx_ren)
  );

  always #5 cyp_clk = ~cyp_clk;

  // fresh bus/FIFO data every cycle
  always @(posedge cyp_clk) begin
    #1;
    usb_fd_i = 16'($urandom);
    tx_rdata = 16'($urandom);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: phase 0=idle 1=addr 2=burst 3=turn
  int m_phase, m_words, m_pkt, m_idle;
  bit m_rd, m_read_next;
  logic [1:0] m_addr;

  // observed statistics for literal checks
  int cyc = 0;
  int wen_cnt = 0, ren_cnt = 0, pkt_cnt = 0;
  int first_rd_cyc = -1, pkt_cyc = -1;
  logic [1:0] pkt_addr;
  bit grants[$];
  logic prev_sloe = 1'b1, prev_oe = 1'b0;

  // compare process: outputs checked against the model every cycle
  always @(negedge cyp_clk) begin
    bit rd_req, wr_req, fire, req;
    logic e_slrd, e_sloe, e_slwr, e_oe, e_wen, e_ren, e_pkt;
    logic [1:0] e_addr;
    cyc++;
    rd_req = usb_flaga && !rx_full;
    wr_req = usb_flagc && !tx_empty;
    if (!rst_n) begin
      chk("rst_slrd", usb_slrd, 1'b1);
      chk("rst_slwr", usb_slwr, 1'b1);
      chk("rst_sloe", usb_sloe, 1'b1);
      chk("rst_oe", usb_fd_oe, 1'b0);
      chk("rst_addr", usb_fifoaddr, 2'b00);
      m_phase = 0; m_words = 0; m_pkt = 0; m_idle = 0;
      m_read_next = 1; m_addr = 2'b00; m_rd = 0;
    end else begin
`ifdef CYP_PKTEND_EN
      fire = (m_phase == 0) && (m_pkt != 0) && (m_idle == TO) && tx_empty;
`else
      fire = 0;
`endif
      e_slrd = 1; e_sloe = 1; e_slwr = 1; e_oe = 0; e_wen = 0; e_ren = 0;
      e_pkt = 1; e_addr = m_addr;
      if (m_phase == 2 && m_rd) begin
        e_sloe = 0;
        if (rd_req) begin e_slrd = 0; e_wen = 1; end
      end
      if (m_phase == 2 && !m_rd) begin
        e_oe = 1;
        if (wr_req) begin e_slwr = 0; e_ren = 1; end
      end
      if (fire) begin e_pkt = 0; e_addr = 2'b10; end
      chk("slcs", usb_slcs, 1'b0);
      chk("slrd", usb_slrd, e_slrd);
      chk("sloe", usb_sloe, e_sloe);
      chk("slwr", usb_slwr, e_slwr);
      chk("fd_oe", usb_fd_oe, e_oe);
      chk("rx_wen", rx_wen, e_wen);
      chk("tx_ren", tx_ren, e_ren);
      chk("pktend", usb_pktend, e_pkt);
      chk("fifoaddr", usb_fifoaddr, e_addr);
      if (e_wen) chk("rx_wdata", rx_wdata, usb_fd_i);
      if (e_oe) chk("fd_o", usb_fd_o, tx_rdata);
      // advance model to the phase after the coming edge
      case (m_phase)
        0: begin
          if (fire) begin
            m_pkt = 0; m_idle = 0;
          end else if (rd_req || wr_req) begin
            m_rd = rd_req && (!wr_req || m_read_next);
            m_read_next = !m_rd;
            m_addr = m_rd ? 2'b00 : 2'b10;
            m_phase = 1;
          end else if (m_pkt != 0 && m_idle < TO) begin
            m_idle++;
          end
        end
        1: begin m_words = 0; m_phase = 2; end
        2: begin
          req = m_rd ? rd_req : wr_req;
          if (req) begin
            m_words++;
            if (!m_rd) m_pkt = (m_pkt + 1) % 512;
            if (m_words == MAXB) m_phase = 3;
          end else begin
            m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
      if (m_phase != 0) m_idle = 0;
    end
    // DUT-side statistics
    if (rx_wen) wen_cnt++;
    if (tx_ren) ren_cnt++;
    if (!usb_pktend) begin pkt_cnt++; pkt_cyc = cyc; pkt_addr = usb_fifoaddr; end
    if (!usb_slrd && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (prev_sloe && !usb_sloe) grants.push_back(1'b1);
    if (!prev_oe && usb_fd_oe) grants.push_back(1'b0);
    prev_sloe = usb_sloe;
    prev_oe   = usb_fd_oe;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cyp_clk);
      #1;
    end
  endtask

  task automatic quiet();
    usb_flaga = 0; usb_flagc = 0; rx_full = 0; tx_empty = 1;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 0;
    tick(2);
    rst_n = 1;
    tick(1);
  endtask

  int t0, w0, r0, p0;

  initial begin
    rst_n = 0;
    quiet();
    usb_fd_i = '0;
    tx_rdata = '0;
    tick(2);
    // reset values
    chk("reset_slrd", usb_slrd, 1'b1);
    chk("reset_slwr", usb_slwr, 1'b1);
    chk("reset_sloe", usb_sloe, 1'b1);
    chk("reset_pktend", usb_pktend, 1'b1);
    chk("reset_fd_oe", usb_fd_oe, 1'b0);
    chk("reset_rx_wen", rx_wen, 1'b0);
    chk("reset_tx_ren", tx_ren, 1'b0);
    chk("reset_fifoaddr", usb_fifoaddr, 2'b00);
    rst_n = 1;
    tick(2);

    // read-only burst: strobe from cycle 3, 256 words
    first_rd_cyc = -1;
    usb_flaga = 1;
    t0 = cyc; w0 = wen_cnt;
    tick(258);
    usb_flaga = 0;
    tick(3);
    chk("rd_first_slrd_cycle", first_rd_cyc - t0, 3);
    chk("rd_burst_words", wen_cnt - w0, 256);

    // both requesting: read, write, read
    do_reset();
    grants.delete();
    usb_flaga = 1; usb_flagc = 1; tx_empty = 0;
    w0 = wen_cnt; r0 = ren_cnt;
    tick(777);
    usb_flaga = 0; usb_flagc = 0;
    tick(3);
    chk("rr_grant_count", grants.size(), 3);
    if (grants.size() >= 3) begin
      chk("rr_grant0_read", grants[0], 1'b1);
      chk("rr_grant1_write", grants[1], 1'b0);
      chk("rr_grant2_read", grants[2], 1'b1);
    end
    chk("rr_read_words", wen_cnt - w0, 512);
    chk("rr_write_words", ren_cnt - r0, 256);

    // rx_full mid-read after 10 words
    do_reset();
    usb_flaga = 1;
    w0 = wen_cnt;
    tick(12);
    rx_full = 1;
    #1;
    chk("full_slrd_same_cycle", usb_slrd, 1'b1);
    chk("full_rx_wen_low", rx_wen, 1'b0);
    chk("full_word_count", wen_cnt - w0, 10);
    tick(1);
    chk("full_turn_sloe", usb_sloe, 1'b1);
    usb_flaga = 0; rx_full = 0;
    tick(3);

    // short write then idle: packet end
    do_reset();
    usb_flagc = 1; tx_empty = 0;
    t0 = cyc; r0 = ren_cnt; p0 = pkt_cnt; pkt_cyc = -1;
    tick(7);
    tx_empty = 1;
    tick(100);
    usb_flagc = 0;
    chk("short_write_words", ren_cnt - r0, 5);
`ifdef CYP_PKTEND_EN
    chk("pktend_pulses", pkt_cnt - p0, 1);
    chk("pktend_cycle", pkt_cyc - t0, 74);
    chk("pktend_addr", pkt_addr, 2'b10);
`else
    chk("pktend_never", pkt_cnt - p0, 0);
`endif

    // reset during a write burst
    do_reset();
    usb_flagc = 1; tx_empty = 0;
    tick(6);
    chk("wr_burst_oe", usb_fd_oe, 1'b1);
    rst_n = 0;
    #1;
    chk("async_slwr", usb_slwr, 1'b1);
    chk("async_fd_oe", usb_fd_oe, 1'b0);
    chk("async_tx_ren", tx_ren, 1'b0);
    tick(2);
    quiet();
    rst_n = 1;
    tick(2);
    chk("post_rst_addr", usb_fifoaddr, 2'b00);
    chk("post_rst_sloe", usb_sloe, 1'b1);
    chk("post_rst_oe", usb_fd_oe, 1'b0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
